bcd_7seg_scan: RTL and testbench

- Downstream consumer of the binary-to-BCD converter's three digit outputs (hundreds, tens, ones).
- Captures those digits on a load strobe, double-buffers them, and time-multiplexes them onto a 3-digit common-anode 7-segment display.
- Provides leading-zero blanking, invalid-digit indication and a one-cycle anti-ghosting gap between digits.
- Sits between the converter and the board pins.

---
 rtl/bcd_7seg_scan.sv | 191 +++++++++++++++++++
 tb/tb_bcd_7seg_scan.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan: captures three BCD digits on a load strobe into a pending buffer and
// transfers them to the display buffer only at a frame boundary, so a frame never shows
// mixed values. The display buffer is time-multiplexed onto a 3-digit common-anode
// 7-segment display. Every digit dwell begins with one all-dark gap cycle against ghosting.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   load       - one-cycle strobe, captures hundreds/tens/ones into the pending buffer
//   hundreds   - BCD hundreds digit
//   tens       - BCD tens digit
//   ones       - BCD ones digit
//   blank_lz   - 1 = suppress leading zeros (sampled live)
//   seg        - segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   an         - digit selects {hundreds,tens,ones}, polarity set by AN_ACTIVE_LOW
//   digit_err  - 1 while any displayed digit is greater than 9
//   frame_done - one-cycle pulse on the last dwell cycle of the ones digit

module bcd_7seg_scan #(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       digit_err,
    output logic       frame_done
);

    localparam int unsigned    CntW   = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]     AnOff  = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {StH, StT, StO} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      pend_h_q, pend_h_d, pend_t_q, pend_t_d, pend_o_q, pend_o_d;
    logic            pend_valid_q, pend_valid_d;
    logic [3:0]      disp_h_q, disp_h_d, disp_t_q, disp_t_d, disp_o_q, disp_o_d;
    logic [6:0]      seg_q, seg_d;
    logic [2:0]      an_q, an_d;
    logic            err_q, err_d;
    logic            frame_done_q, frame_done_d;

    logic            dwell_end;
    logic            boundary;
    logic [3:0]      cur_digit;
    logic            cur_blank;
    logic [2:0]      an_ah;
    logic [6:0]      seg_ah;

    // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    always_comb begin
        dwell_end = (cnt_q == CntMax);
        boundary  = dwell_end && (state_q == StO);

        // Scan counter and digit FSM
        cnt_d   = dwell_end ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        if (dwell_end) begin
            case (state_q)
                StH:     state_d = StT;
                StT:     state_d = StO;
                default: state_d = StH;
            endcase
        end

        // Double buffer: the transfer uses the old pending value, so a load on the
        // boundary cycle lands in pending and waits for the next boundary.
        pend_h_d     = pend_h_q;
        pend_t_d     = pend_t_q;
        pend_o_d     = pend_o_q;
        pend_valid_d = pend_valid_q;
        disp_h_d     = disp_h_q;
        disp_t_d     = disp_t_q;
        disp_o_d     = disp_o_q;
        if (boundary && pend_valid_q) begin
            disp_h_d     = pend_h_q;
            disp_t_d     = pend_t_q;
            disp_o_d     = pend_o_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_h_d     = hundreds;
            pend_t_d     = tens;
            pend_o_d     = ones;
            pend_valid_d = 1'b1;
        end

        // Digit selection for the current count; count 0 is the dark gap.
        cur_digit = disp_o_q;
        cur_blank = 1'b0;
        an_ah     = 3'b000;
        case (state_q)
            StH: begin
                cur_digit = disp_h_q;
                cur_blank = blank_lz && (disp_h_q == 4'd0);
                an_ah     = 3'b100;
            end
            StT: begin
                cur_digit = disp_t_q;
                cur_blank = blank_lz && (disp_h_q == 4'd0) && (disp_t_q == 4'd0);
                an_ah     = 3'b010;
            end
            default: begin
                cur_digit = disp_o_q;
                cur_blank = 1'b0;
                an_ah     = 3'b001;
            end
        endcase

        seg_ah = cur_blank ? 7'h00 : decode(cur_digit);
        if (cnt_q == '0) begin
            seg_ah = 7'h00;
            an_ah  = 3'b000;
        end

        seg_d = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
        an_d  = AN_ACTIVE_LOW ? ~an_ah : an_ah;

        err_d = (disp_h_q > 4'd9) || (disp_t_q > 4'd9) || (disp_o_q > 4'd9);

        // Look ahead one cycle so the registered pulse coincides with the boundary cycle.
        frame_done_d = (state_d == StO) && (cnt_d == CntMax);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StH;
            cnt_q        <= '0;
            pend_h_q     <= 4'd0;
            pend_t_q     <= 4'd0;
            pend_o_q     <= 4'd0;
            pend_valid_q <= 1'b0;
            disp_h_q     <= 4'd0;
            disp_t_q     <= 4'd0;
            disp_o_q     <= 4'd0;
            seg_q        <= SegOff;
            an_q         <= AnOff;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_h_q     <= pend_h_d;
            pend_t_q     <= pend_t_d;
            pend_o_q     <= pend_o_d;
            pend_valid_q <= pend_valid_d;
            disp_h_q     <= disp_h_d;
            disp_t_q     <= disp_t_d;
            disp_o_q     <= disp_o_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_err  = err_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
module tb_bcd_7seg_scan;

    localparam int unsigned RD  = 4;
    localparam int unsigned F   = 3 * RD;
    localparam bit          SAL = 1'b1;
    localparam bit          AAL = 1'b1;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blank_lz;
    logic [6:0] seg;
    logic [2:0] an;
    logic       digit_err;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    bcd_7seg_scan #(
        .REFRESH_DIV   (RD),
        .SEG_ACTIVE_LOW(SAL),
        .AN_ACTIVE_LOW (AAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .an        (an),
        .digit_err (digit_err),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Segment patterns straight from the digit table.
    function automatic logic [6:0] seg_pat(input logic [3:0] v);
        logic [6:0] tab [10];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (v > 4'd9) return 7'h40;
        return tab[v];
    endfunction

    // Behavioural model: position in the frame is just (edges since reset) mod 3*RD.
    int         m_n;
    logic [3:0] m_pend [3];
    logic [3:0] m_disp [3];
    bit         m_pv;
    logic [6:0] e_seg;
    logic [2:0] e_an;
    logic       e_err;
    logic       e_fd;

    initial forever begin : model_step
        int         pos;
        int         dig;
        int         cnt;
        bit         blank;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_n    = 0;
            m_pend = '{4'd0, 4'd0, 4'd0};
            m_disp = '{4'd0, 4'd0, 4'd0};
            m_pv   = 1'b0;
            e_seg  = 7'h00;
            e_an   = 3'b000;
            e_err  = 1'b0;
            e_fd   = 1'b0;
        end else begin
            pos   = m_n % F;
            dig   = pos / RD;
            cnt   = pos % RD;
            e_err = (m_disp[0] > 9) || (m_disp[1] > 9) || (m_disp[2] > 9);
            if (cnt == 0) begin
                e_seg = 7'h00;
                e_an  = 3'b000;
            end else begin
                e_an  = 3'b100 >> dig;
                blank = blank_lz && ((dig == 0 && m_disp[0] == 0) ||
                                     (dig == 1 && m_disp[0] == 0 && m_disp[1] == 0));
                e_seg = blank ? 7'h00 : seg_pat(m_disp[dig]);
            end
            e_fd = ((m_n + 1) % F) == (F - 1);
            if (pos == F - 1 && m_pv) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end
            if (load) begin
                m_pend[0] = hundreds;
                m_pend[1] = tens;
                m_pend[2] = ones;
                m_pv      = 1'b1;
            end
            m_n++;
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    initial forever begin : compare
        logic [6:0] xs;
        logic [2:0] xa;
        @(negedge clk);
        if (cmp_en) begin
            xs = SAL ? ~e_seg : e_seg;
            xa = AAL ? ~e_an : e_an;
            chk("model_seg", {25'd0, seg}, {25'd0, xs});
            chk("model_an", {29'd0, an}, {29'd0, xa});
            chk("model_digit_err", {31'd0, digit_err}, {31'd0, e_err});
            chk("model_frame_done", {31'd0, frame_done}, {31'd0, e_fd});
        end
    end

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        @(negedge clk);
        hundreds = h;
        tens     = t;
        ones     = o;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Returns at the negedge of the boundary cycle (frame_done high).
    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * F && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL wait_frame_done: got timeout, expected pulse within %0d cycles", 2 * F);
        end
    endtask

    task automatic pin(input string name, input logic [2:0] a, input logic [6:0] s);
        chk({name, "_an"}, {29'd0, an}, {29'd0, a});
        chk({name, "_seg"}, {25'd0, seg}, {25'd0, s});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b1;
        load     = 1'b0;
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd0;
        blank_lz = 1'b0;
        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        pin("reset", 3'b111, 7'h7F);
        chk("reset_err", {31'd0, digit_err}, 32'd0);
        chk("reset_fd", {31'd0, frame_done}, 32'd0);
        skip(2);
        rst_n = 1'b1;

        // First gap, then hundreds for RD-1 cycles, then gap.
        skip(1); pin("first_gap", 3'b111, 7'h7F);
        skip(1); pin("first_h", 3'b011, 7'h40);
        skip(2); pin("last_h", 3'b011, 7'h40);
        skip(1); pin("second_gap", 3'b111, 7'h7F);

        // 123
        do_load(4'd1, 4'd2, 4'd3);
        wait_fd();
        skip(3); pin("d123_h", 3'b011, 7'h79);
        skip(4); pin("d123_t", 3'b101, 7'h24);
        skip(4); pin("d123_o", 3'b110, 7'h30);
        chk("fd_low", {31'd0, frame_done}, 32'd0);
        skip(1);
        chk("fd_period", {31'd0, frame_done}, 32'd1);

        // 007 with blanking, then without
        blank_lz = 1'b1;
        do_load(4'd0, 4'd0, 4'd7);
        wait_fd();
        skip(3); pin("lz_h", 3'b011, 7'h7F);
        skip(4); pin("lz_t", 3'b101, 7'h7F);
        skip(4); pin("lz_o", 3'b110, 7'h78);
        blank_lz = 1'b0;
        skip(4); pin("nolz_h", 3'b011, 7'h40);

        // Last load wins
        do_load(4'd1, 4'd2, 4'd3);
        do_load(4'd4, 4'd5, 4'd6);
        wait_fd();
        skip(3); pin("d456_h", 3'b011, 7'h19);

        // Load on the boundary cycle: applied one frame later
        wait_fd();
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd12;
        load     = 1'b1;
        skip(1);
        load = 1'b0;
        skip(2); pin("held_456_h", 3'b011, 7'h19);
        wait_fd();
        skip(1); chk("err_before", {31'd0, digit_err}, 32'd0);
        skip(1); chk("err_after", {31'd0, digit_err}, 32'd1);
        skip(9); pin("dash_o", 3'b110, 7'h3F);

        // Async reset in the middle of the tens dwell
        skip(8);
        blank_lz = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        pin("async_rst", 3'b111, 7'h7F);
        chk("async_rst_err", {31'd0, digit_err}, 32'd0);
        skip(1);
        rst_n = 1'b1;
        skip(1); pin("rst_gap", 3'b111, 7'h7F);
        skip(1); pin("rst_h_blank", 3'b011, 7'h7F);
        skip(4); pin("rst_t_blank", 3'b101, 7'h7F);
        skip(4); pin("rst_o_zero", 3'b110, 7'h40);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            load     = ($urandom_range(0, 7) == 0);
            hundreds = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            tens     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            ones     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
        end
        @(negedge clk);
        load = 1'b0;
        skip(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
